wb_mailbox: RTL and testbench
=============================

WB_MAILBOX -- requirements
Module: wb_mailbox

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, entries per FIFO; power of two, 2..128.
REQ-002 Parameter CNT_W, default $clog2(FIFO_DEPTH)+1, occupancy counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 wb_stb_i  input  1  Wishbone strobe, pre-gated by the host address decode.
REQ-006 wb_cyc_i  input  1  Wishbone cycle.
REQ-007 wb_we_i  input  1  write enable.
REQ-008 wb_adr_i  input  32  byte address; only bits [3:2] decoded.
REQ-009 wb_dat_i  input  32  write data.
REQ-010 wb_sel_i  input  4  byte select.
REQ-011 wb_dat_o  output  32  read data, registered, valid with wb_ack_o.
REQ-012 wb_ack_o  output  1  single-cycle acknowledge.
REQ-013 out_valid/out_data[7:0]/out_ready  output/output/input  TX stream toward the external device.
REQ-014 in_valid/in_data[7:0]/in_ready  input/input/output  RX stream from the external device.

Function
REQ-015 Bus FSM states IDLE, ACK; IDLE->ACK when wb_stb_i & wb_cyc_i; ACK->IDLE unconditionally; wb_ack_o=1 only in ACK.
REQ-016 Access accepted in the IDLE->ACK cycle; all register side effects occur on that edge; latency stb-to-ack exactly 1 cycle; a stb held across ACK is not re-accepted until IDLE.
REQ-017 Offset 0x0 DATA: write with wb_sel_i[0]=1 pushes wb_dat_i[7:0] into TX FIFO; read pops RX FIFO, returns {24'h0, byte}.
REQ-018 DATA write with TX full: byte dropped, STATUS.TX_OVF set; DATA read with RX empty: returns 0, STATUS.RX_UNF set, no pointer change.
REQ-019 Offset 0x4 STATUS (read): [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] TX_OVF, [5] RX_UNF, [15:8] tx_count, [23:16] rx_count, other bits 0; write 1 to bit 4/5 clears it (W1C, needs wb_sel_i[0]).
REQ-020 Offset 0x8 CTRL: [0] ENABLE read/write; [1] TX_FLUSH, [2] RX_FLUSH write-1 self-clearing, always read 0.
REQ-021 Offset 0xC SCRATCH: 32-bit read/write, per-byte write under wb_sel_i.
REQ-022 out_valid = ENABLE & !tx_empty; out_data = TX head; pop on out_valid & out_ready.
REQ-023 in_ready = ENABLE & !rx_full; push on in_valid & in_ready.
REQ-024 Full/empty decisions use pre-edge counts; simultaneous push and pop on a non-full, non-empty FIFO both occur, count unchanged; push into full FIFO dropped even if a pop occurs the same cycle.
REQ-025 Flush empties the FIFO on the CTRL-write edge and overrides any push/pop in that cycle; sticky flags unaffected.
REQ-026 Pointers wrap modulo FIFO_DEPTH; counts saturate at 0..FIFO_DEPTH by construction.
REQ-027 ENABLE=0 blocks only the stream side; bus access to FIFOs stays functional.

Reset
REQ-028 While rst=1 on a clock edge: FSM IDLE, wb_ack_o=0, wb_dat_o=0, FIFOs empty, flags 0, ENABLE 0, SCRATCH 0, out_valid=0, in_ready=0.
REQ-029 Reset during ACK aborts the access: no ack on the next cycle, no further side effects.

Configuration
REQ-030 Macro WB_MAILBOX_IRQ_EN defined: output irq (1 bit) added, CTRL[3] RX_IE, CTRL[4] TX_IE; irq registered = (RX_IE & !rx_empty) | (TX_IE & tx_empty), reset 0.
REQ-031 Macro undefined: no irq port, CTRL[4:3] read 0 and ignore writes.

Verification
REQ-032 Write 0x1 to CTRL, write 0xA5 to DATA -> ack 1 cycle after stb; out_valid=1, out_data=0xA5; STATUS reads tx_count=1.
REQ-033 9 DATA writes with out_ready=0 (depth 8) -> STATUS tx_full=1, TX_OVF=1, tx_count=8; write 0x10 to STATUS -> TX_OVF=0.
REQ-034 Push 0x3C via in_valid with ENABLE=1, read DATA -> 0x0000003C; second read -> 0, RX_UNF=1.
REQ-035 TX holding 4 bytes, DATA write same cycle as out_ready pop -> tx_count stays 4; then CTRL write 0x3 -> tx_count=0, out_valid=0 next cycle.
REQ-036 Write SCRATCH 0xDEADBEEF sel=0xF, then 0x00000011 sel=0x1 -> read 0xDEADBE11; assert rst during an ACK cycle -> wb_ack_o=0 following cycle, all registers at reset values.

Source files
------------

// File: rtl/wb_mailbox_if.sv
// Wishbone classic slave bus bundle for the mailbox: host-driven request fields plus registered response.
// Master drives the strobe/cycle/address/data/select; slave returns read data and a one-cycle ack.
interface wb_mailbox_if;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_mailbox.sv
// Wishbone mailbox bridging the bus to byte TX/RX streams via two FIFOs; optional irq under WB_MAILBOX_IRQ_EN.
// Latency: bus ack exactly one cycle after an accepted strobe; stream pops/pushes take effect on the same edge.
// Backpressure: out_valid/out_ready and in_valid/in_ready stream handshakes; full TX drops bus writes, empty RX reads 0.
module wb_mailbox #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    wb_mailbox_if.slave bus,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready
`ifdef WB_MAILBOX_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, ACK} state_t;
    state_t state, state_n;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.wb_stb_i && bus.wb_cyc_i) state_n = ACK;
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    logic       accept, wr_en, rd_en, sel0;
    logic [1:0] reg_sel;
    assign accept  = (state == IDLE) && bus.wb_stb_i && bus.wb_cyc_i;
    assign wr_en   = accept && bus.wb_we_i;
    assign rd_en   = accept && !bus.wb_we_i;
    assign sel0    = bus.wb_sel_i[0];
    assign reg_sel = bus.wb_adr_i[3:2];
    assign bus.wb_ack_o = (state == ACK);

    logic unused_adr_bits;
    assign unused_adr_bits = ^{bus.wb_adr_i[31:4], bus.wb_adr_i[1:0]};

    logic [7:0]     tx_mem [FIFO_DEPTH];
    logic [7:0]     rx_mem [FIFO_DEPTH];
    logic [AW-1:0]  tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CNT_W-1:0] tx_cnt, rx_cnt;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic enable, tx_ovf, rx_unf;
    logic [31:0] scratch;
`ifdef WB_MAILBOX_IRQ_EN
    logic rx_ie, tx_ie;
`endif

    assign tx_full  = (tx_cnt == CNT_W'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == CNT_W'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt == '0);

    logic ctrl_wr, tx_wr_req, tx_push, tx_pop, tx_flush;
    logic rx_rd_req, rx_push, rx_pop, rx_flush;
    assign ctrl_wr   = wr_en && sel0 && (reg_sel == 2'd2);
    assign tx_wr_req = wr_en && sel0 && (reg_sel == 2'd0);
    assign tx_push   = tx_wr_req && !tx_full;
    assign tx_pop    = out_valid && out_ready;
    assign tx_flush  = ctrl_wr && bus.wb_dat_i[1];
    assign rx_rd_req = rd_en && (reg_sel == 2'd0);
    assign rx_pop    = rx_rd_req && !rx_empty;
    assign rx_push   = in_valid && in_ready;
    assign rx_flush  = ctrl_wr && bus.wb_dat_i[2];

    assign out_valid = enable && !tx_empty;
    assign out_data  = tx_mem[tx_rd];
    assign in_ready  = enable && !rx_full;

    // Storage carries no reset; occupancy is tracked purely by the counters.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= bus.wb_dat_i[7:0];
        if (rx_push) rx_mem[rx_wr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst || tx_flush) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + AW'(1);
            if (tx_pop)  tx_rd <= tx_rd + AW'(1);
            tx_cnt <= tx_cnt + CNT_W'(tx_push) - CNT_W'(tx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rx_flush) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + AW'(1);
            if (rx_pop)  rx_rd <= rx_rd + AW'(1);
            rx_cnt <= rx_cnt + CNT_W'(rx_push) - CNT_W'(rx_pop);
        end
    end

    logic [31:0] status_word, ctrl_word, rdata;
    assign status_word = {8'h00, 8'(rx_cnt), 8'(tx_cnt), 2'b00,
                          rx_unf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full};
`ifdef WB_MAILBOX_IRQ_EN
    assign ctrl_word = {27'h0, tx_ie, rx_ie, 2'b00, enable};
`else
    assign ctrl_word = {31'h0, enable};
`endif

    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0:    rdata = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd]};
            2'd1:    rdata = status_word;
            2'd2:    rdata = ctrl_word;
            default: rdata = scratch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf          <= 1'b0;
            rx_unf          <= 1'b0;
            enable          <= 1'b0;
            scratch         <= '0;
            bus.wb_dat_o    <= '0;
`ifdef WB_MAILBOX_IRQ_EN
            rx_ie           <= 1'b0;
            tx_ie           <= 1'b0;
`endif
        end else begin
            if (tx_wr_req && tx_full)
                tx_ovf <= 1'b1;
            else if (wr_en && sel0 && (reg_sel == 2'd1) && bus.wb_dat_i[4])
                tx_ovf <= 1'b0;
            if (rx_rd_req && rx_empty)
                rx_unf <= 1'b1;
            else if (wr_en && sel0 && (reg_sel == 2'd1) && bus.wb_dat_i[5])
                rx_unf <= 1'b0;
            if (ctrl_wr) begin
                enable <= bus.wb_dat_i[0];
`ifdef WB_MAILBOX_IRQ_EN
                rx_ie  <= bus.wb_dat_i[3];
                tx_ie  <= bus.wb_dat_i[4];
`endif
            end
            if (wr_en && (reg_sel == 2'd3)) begin
                for (int b = 0; b < 4; b++)
                    if (bus.wb_sel_i[b]) scratch[8*b +: 8] <= bus.wb_dat_i[8*b +: 8];
            end
            if (accept) bus.wb_dat_o <= bus.wb_we_i ? 32'h0 : rdata;
        end
    end

`ifdef WB_MAILBOX_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= (rx_ie && !rx_empty) || (tx_ie && tx_empty);
    end
`endif
endmodule

// File: tb/tb_wb_mailbox.sv
// Randomised and directed bench for wb_mailbox against a queue-based register/FIFO model.
module tb_wb_mailbox;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, out_ready, in_valid, out_valid, in_ready;
    logic [7:0] in_data, out_data;
    wb_mailbox_if bus();
`ifdef WB_MAILBOX_IRQ_EN
    logic irq;
`endif

    wb_mailbox #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready)
`ifdef WB_MAILBOX_IRQ_EN
        , .irq(irq)
`endif
    );

    logic [7:0]  tq[$];
    logic [7:0]  rq[$];
    bit          m_en, m_ovf, m_unf;
    logic [31:0] m_scr;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic [31:0] m_status();
        return {8'h00, 8'(rq.size()), 8'(tq.size()), 2'b00, m_unf, m_ovf,
                (rq.size() == 0), (rq.size() == DEPTH), (tq.size() == 0), (tq.size() == DEPTH)};
    endfunction

    task automatic model_reset();
        tq.delete(); rq.delete();
        m_en = 0; m_ovf = 0; m_unf = 0; m_scr = '0;
    endtask

    // One clock edge: check stream outputs against the model, advance the model, then advance time.
    task automatic tick(input bit acc, input bit we, input logic [1:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd);
        bit txv, inr, pop_tx, push_rx, push_tx, txfl, rxfl;
        logic [7:0] rx_byte;
        txv = m_en && (tq.size() != 0);
        inr = m_en && (rq.size() < DEPTH);
        n_checks++;
        if (out_valid !== txv) $display("FAIL out_valid got %b exp %b", out_valid, txv);
        else n_pass++;
        if (txv) begin
            n_checks++;
            if (out_data !== tq[0]) $display("FAIL out_data got %h exp %h", out_data, tq[0]);
            else n_pass++;
        end
        n_checks++;
        if (in_ready !== inr) $display("FAIL in_ready got %b exp %b", in_ready, inr);
        else n_pass++;
        pop_tx  = txv && out_ready;
        push_rx = inr && in_valid;
        rx_byte = in_data;
        push_tx = 0; txfl = 0; rxfl = 0; rd = '0;
        if (acc && !we) begin
            case (a)
                2'd0: if (rq.size() != 0) rd = {24'h0, rq.pop_front()};
                      else m_unf = 1;
                2'd1: rd = m_status();
                2'd2: rd = {31'h0, m_en};
                default: rd = m_scr;
            endcase
        end else if (acc) begin
            case (a)
                2'd0: if (s[0]) begin
                          if (tq.size() < DEPTH) push_tx = 1;
                          else m_ovf = 1;
                      end
                2'd1: if (s[0]) begin
                          if (d[4]) m_ovf = 0;
                          if (d[5]) m_unf = 0;
                      end
                2'd2: if (s[0]) begin
                          m_en = d[0]; txfl = d[1]; rxfl = d[2];
                      end
                default: for (int b = 0; b < 4; b++)
                             if (s[b]) m_scr[8*b +: 8] = d[8*b +: 8];
            endcase
        end
        if (pop_tx)  void'(tq.pop_front());
        if (push_tx) tq.push_back(d[7:0]);
        if (push_rx) rq.push_back(rx_byte);
        if (txfl) tq.delete();
        if (rxfl) rq.delete();
        @(posedge clk); #1;
    endtask

    // Full bus access; stream inputs apply only during the accept cycle.
    task automatic access(input bit we, input logic [1:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
        logic [31:0] exp, dummy;
        bus.wb_stb_i = 1; bus.wb_cyc_i = 1; bus.wb_we_i = we;
        bus.wb_adr_i = {$urandom_range(0, 255), 20'h0, a, 2'($urandom_range(0, 3))};
        bus.wb_dat_i = d; bus.wb_sel_i = s;
        n_checks++;
        if (bus.wb_ack_o !== 1'b0) $display("FAIL ack_before_edge got %b exp 0", bus.wb_ack_o);
        else n_pass++;
        tick(1, we, a, d, s, exp);
        n_checks++;
        if (bus.wb_ack_o !== 1'b1) $display("FAIL ack_latency got %b exp 1", bus.wb_ack_o);
        else n_pass++;
        if (!we) begin
            n_checks++;
            if (bus.wb_dat_o !== exp) $display("FAIL rdata adr %0d got %h exp %h", a, bus.wb_dat_o, exp);
            else n_pass++;
        end
        rd = bus.wb_dat_o;
        bus.wb_stb_i = 0; bus.wb_cyc_i = 0; bus.wb_we_i = 0;
        out_ready = 0; in_valid = 0;
        tick(0, 0, 2'd0, 32'h0, 4'h0, dummy);
        n_checks++;
        if (bus.wb_ack_o !== 1'b0) $display("FAIL ack_single_cycle got %b exp 0", bus.wb_ack_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.wb_ack_o !== 1'b0 || bus.wb_dat_o !== 32'h0)
            $display("FAIL reset_bus got ack %b dat %h exp 0 0", bus.wb_ack_o, bus.wb_dat_o);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL reset_stream got %b %b exp 0 0", out_valid, in_ready);
        else n_pass++;
        rst = 0;
        model_reset();
        access(0, 2'd1, 0, 4'hF, rd);
        n_checks++;
        if (rd !== 32'h0000_000A) $display("FAIL reset_status got %h exp 0000000a", rd);
        else n_pass++;
        access(0, 2'd2, 0, 4'hF, rd);
        access(0, 2'd3, 0, 4'hF, rd);
    endtask

    task automatic test_basic_tx();
        logic [31:0] rd;
        access(1, 2'd2, 32'h1, 4'hF, rd);
        access(1, 2'd0, 32'hA5, 4'h1, rd);
        access(0, 2'd1, 0, 4'hF, rd);
        n_checks++;
        if (rd !== 32'h0000_0108) $display("FAIL basic_status got %h exp 00000108", rd);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        access(1, 2'd2, 32'h3, 4'h1, rd);
        for (int i = 0; i < 9; i++) access(1, 2'd0, 32'($urandom), 4'h1, rd);
        access(0, 2'd1, 0, 4'hF, rd);
        n_checks++;
        if (rd !== 32'h0000_0819) $display("FAIL ovf_status got %h exp 00000819", rd);
        else n_pass++;
        access(1, 2'd1, 32'h10, 4'h1, rd);
        access(0, 2'd1, 0, 4'hF, rd);
        n_checks++;
        if (rd !== 32'h0000_0809) $display("FAIL ovf_clear got %h exp 00000809", rd);
        else n_pass++;
    endtask

    task automatic test_rx();
        logic [31:0] rd, dummy;
        in_valid = 1; in_data = 8'h3C;
        tick(0, 0, 2'd0, 32'h0, 4'h0, dummy);
        in_valid = 0;
        access(0, 2'd0, 0, 4'hF, rd);
        n_checks++;
        if (rd !== 32'h0000_003C) $display("FAIL rx_read got %h exp 0000003c", rd);
        else n_pass++;
        access(0, 2'd0, 0, 4'hF, rd);
        n_checks++;
        if (rd !== 32'h0) $display("FAIL rx_empty_read got %h exp 0", rd);
        else n_pass++;
        access(0, 2'd1, 0, 4'hF, rd);
        n_checks++;
        if (rd[5] !== 1'b1) $display("FAIL rx_unf got %b exp 1", rd[5]);
        else n_pass++;
        access(1, 2'd1, 32'h20, 4'h1, rd);
    endtask

    task automatic test_simul_push_pop();
        logic [31:0] rd;
        access(1, 2'd2, 32'h3, 4'h1, rd);
        for (int i = 0; i < 4; i++) access(1, 2'd0, 32'(8'h50 + i), 4'h1, rd);
        out_ready = 1;
        access(1, 2'd0, 32'h66, 4'h1, rd);
        access(0, 2'd1, 0, 4'hF, rd);
        n_checks++;
        if (rd[15:8] !== 8'd4) $display("FAIL simul_count got %0d exp 4", rd[15:8]);
        else n_pass++;
        access(1, 2'd2, 32'h3, 4'h1, rd);
        access(0, 2'd1, 0, 4'hF, rd);
        n_checks++;
        if (rd[15:8] !== 8'd0) $display("FAIL flush_count got %0d exp 0", rd[15:8]);
        else n_pass++;
    endtask

    task automatic test_held_stb();
        logic [31:0] rd, dummy;
        bus.wb_stb_i = 1; bus.wb_cyc_i = 1; bus.wb_we_i = 1;
        bus.wb_adr_i = 32'h0; bus.wb_dat_i = 32'h77; bus.wb_sel_i = 4'h1;
        tick(1, 1, 2'd0, 32'h77, 4'h1, dummy);
        tick(0, 0, 2'd0, 32'h0, 4'h0, dummy);
        n_checks++;
        if (bus.wb_ack_o !== 1'b0) $display("FAIL held_stb_ack got %b exp 0", bus.wb_ack_o);
        else n_pass++;
        bus.wb_stb_i = 0; bus.wb_cyc_i = 0; bus.wb_we_i = 0;
        access(0, 2'd1, 0, 4'hF, rd);
    endtask

    task automatic test_scratch();
        logic [31:0] rd;
        access(1, 2'd3, 32'hDEADBEEF, 4'hF, rd);
        access(1, 2'd3, 32'h00000011, 4'h1, rd);
        access(0, 2'd3, 0, 4'hF, rd);
        n_checks++;
        if (rd !== 32'hDEADBE11) $display("FAIL scratch got %h exp deadbe11", rd);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] rd, d, dummy;
        logic [1:0]  a;
        bit          we;
        for (int i = 0; i < 400; i++) begin
            out_ready = 1'($urandom); in_valid = 1'($urandom); in_data = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                tick(0, 0, 2'd0, 32'h0, 4'h0, dummy);
                out_ready = 0; in_valid = 0;
            end else begin
                a = 2'($urandom); we = 1'($urandom); d = $urandom;
                if (a == 2'd2) begin
                    d = d & ~32'h18;
                    if ($urandom_range(0, 7) != 0) d[2:1] = 2'b00;
                    d[0] = ($urandom_range(0, 3) != 0);
                end
                access(we, a, d, 4'($urandom), rd);
            end
        end
    endtask

    task automatic test_reset_during_ack();
        logic [31:0] rd, dummy;
        access(1, 2'd2, 32'h1, 4'h1, rd);
        access(1, 2'd0, 32'h99, 4'h1, rd);
        bus.wb_stb_i = 1; bus.wb_cyc_i = 1; bus.wb_we_i = 1;
        bus.wb_adr_i = 32'hC; bus.wb_dat_i = 32'h12345678; bus.wb_sel_i = 4'hF;
        tick(1, 1, 2'd3, 32'h12345678, 4'hF, dummy);
        rst = 1;
        bus.wb_stb_i = 0; bus.wb_cyc_i = 0; bus.wb_we_i = 0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.wb_ack_o !== 1'b0 || bus.wb_dat_o !== 32'h0)
            $display("FAIL rst_in_ack got ack %b dat %h exp 0 0", bus.wb_ack_o, bus.wb_dat_o);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL rst_in_ack_stream got %b %b exp 0 0", out_valid, in_ready);
        else n_pass++;
        rst = 0;
        model_reset();
        access(0, 2'd1, 0, 4'hF, rd);
        access(0, 2'd2, 0, 4'hF, rd);
        access(0, 2'd3, 0, 4'hF, rd);
    endtask

    initial begin
        rst = 1; out_ready = 0; in_valid = 0; in_data = '0;
        bus.wb_stb_i = 0; bus.wb_cyc_i = 0; bus.wb_we_i = 0;
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
        model_reset();
        test_reset();
        test_basic_tx();
        test_overflow();
        test_rx();
        test_simul_push_pop();
        test_held_stb();
        test_scratch();
        test_random();
        test_reset_during_ack();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
